layer_sequencer: RTL and testbench

- Sits directly downstream of output_aggregator and closes the layer-multiplexing loop.
- Waits until the aggregator reports all neuron outputs valid, then latches the layer's outputs into a buffer.
- Replays the buffered values as inputs to the next layer and re-issues layer start, for NUM_LAYERS passes.
- After the last pass, presents the network result on a valid/ready handshake; a watchdog flags a stalled layer.

---
 rtl/nn_pkg.sv | 22 ++
 rtl/watchdog_timer.sv | 30 +++
 rtl/layer_sequencer.sv | 112 +++++++++++
 tb/tb_layer_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared constants and types for the layer-multiplexed neuron pipeline.
// Also used by output_aggregator, so lane counts and widths live here.
package nn_pkg;

  localparam int NEURONS    = 6;
  localparam int OUT_WIDTH  = 8;
  localparam int NUM_LAYERS = 3;
  localparam int LAYER_BITS = 2;
  localparam int VEC_W      = NEURONS * OUT_WIDTH;

  localparam logic [NEURONS-1:0]    ALL_VALID  = {NEURONS{1'b1}};
  localparam logic [LAYER_BITS-1:0] LAST_LAYER = LAYER_BITS'(NUM_LAYERS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

endpackage

// File: rtl/watchdog_timer.sv
// Stall watchdog: counts enabled cycles after a clear and reports when the
// count reaches TIMEOUT. The count saturates there so it never wraps.
module watchdog_timer #(
  parameter int TIMEOUT      = 1023,
  parameter int TIMEOUT_BITS = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMEOUT_BITS-1:0] LIMIT = TIMEOUT_BITS'(TIMEOUT);

  logic [TIMEOUT_BITS-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + TIMEOUT_BITS'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/layer_sequencer.sv
// Replays each layer's aggregated outputs as the next layer's inputs for
// NUM_LAYERS passes, then offers the final vector to a consumer.
module layer_sequencer
  import nn_pkg::*;
#(
  parameter int TIMEOUT      = 1023,
  parameter int TIMEOUT_BITS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  net_start,
  input  logic [VEC_W-1:0]      net_inputs,
  input  logic [NEURONS-1:0]    agg_valid,
  input  logic [VEC_W-1:0]      agg_values,
  output logic                  layer_start,
  output logic [VEC_W-1:0]      layer_inputs,
  output logic [LAYER_BITS-1:0] layer_index,
  output logic                  busy,
  output logic                  result_valid,
  output logic [VEC_W-1:0]      result_values,
  input  logic                  result_ready,
  output logic                  error,
  output state_e                state_dbg
);

  state_e           state;
  logic [VEC_W-1:0] buffer;
  logic             all_valid;
  logic             wd_clear;
  logic             wd_enable;
  logic             wd_expired;

  assign all_valid = (agg_valid == ALL_VALID);
  assign wd_clear  = (state == ST_START);
  assign wd_enable = (state == ST_WAIT) && !all_valid;

  watchdog_timer #(
    .TIMEOUT      (TIMEOUT),
    .TIMEOUT_BITS (TIMEOUT_BITS)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  // Result handshake: result_valid rises on DONE entry and result_values is
  // held until the cycle result_valid && result_ready, which ends the transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      buffer       <= '0;
      layer_index  <= '0;
      layer_start  <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      error        <= 1'b0;
    end else begin
      layer_start <= 1'b0;
      case (state)
        ST_IDLE, ST_ERR: begin
          if (net_start) begin
            buffer      <= net_inputs;
            layer_index <= '0;
            error       <= 1'b0;
            layer_start <= 1'b1;
            busy        <= 1'b1;
            state       <= ST_START;
          end
        end
        ST_START: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (all_valid) begin
            buffer <= agg_values;
            if (layer_index == LAST_LAYER) begin
              busy         <= 1'b0;
              result_valid <= 1'b1;
              state        <= ST_DONE;
            end else begin
              layer_index <= layer_index + LAYER_BITS'(1);
              layer_start <= 1'b1;
              state       <= ST_START;
            end
          end else if (wd_expired) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= ST_ERR;
          end
        end
        ST_DONE: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: begin
          busy         <= 1'b0;
          result_valid <= 1'b0;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

  assign layer_inputs  = buffer;
  assign result_values = buffer;
  assign state_dbg     = state;

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: directed layer passes, timeout,
// ignored starts and asynchronous mid-operation reset.
module tb_layer_sequencer;
  import nn_pkg::*;

  localparam int TIMEOUT = 1023;
  localparam int W       = VEC_W;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic                  net_start    = 1'b0;
  logic [W-1:0]          net_inputs   = '0;
  logic [NEURONS-1:0]    agg_valid    = '0;
  logic [W-1:0]          agg_values   = '0;
  logic                  result_ready = 1'b0;
  logic                  layer_start;
  logic [W-1:0]          layer_inputs;
  logic [LAYER_BITS-1:0] layer_index;
  logic                  busy;
  logic                  result_valid;
  logic [W-1:0]          result_values;
  logic                  error;
  state_e                state_dbg;

  layer_sequencer #(.TIMEOUT(TIMEOUT), .TIMEOUT_BITS(10)) dut (
    .clk           (clk),
    .rst           (rst),
    .net_start     (net_start),
    .net_inputs    (net_inputs),
    .agg_valid     (agg_valid),
    .agg_values    (agg_values),
    .layer_start   (layer_start),
    .layer_inputs  (layer_inputs),
    .layer_index   (layer_index),
    .busy          (busy),
    .result_valid  (result_valid),
    .result_values (result_values),
    .result_ready  (result_ready),
    .error         (error),
    .state_dbg     (state_dbg)
  );

  // scoreboard
  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] res_q[$];

  function automatic logic [W-1:0] lanes(input logic [7:0] base);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < NEURONS; i++) v[i*OUT_WIDTH +: OUT_WIDTH] = base + 8'(i);
    return v;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // driver tasks
  task automatic step;
    @(negedge clk);
  endtask

  task automatic pop_cmp(input string tag, input bit from_res, input logic [W-1:0] obs);
    logic [W-1:0] e;
    if (from_res) begin
      check_val({tag, "_qsize"}, 64'(res_q.size()), 64'd1);
      if (res_q.size() > 0) begin
        e = res_q.pop_front();
        check_val(tag, 64'(obs), 64'(e));
      end
    end else begin
      check_val({tag, "_qsize"}, 64'(exp_q.size()), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_val(tag, 64'(obs), 64'(e));
      end
    end
  endtask

  // Pulse net_start from IDLE/ERR; returns at the negedge of the START cycle.
  task automatic start_net(input logic [W-1:0] v);
    net_inputs = v;
    net_start  = 1'b1;
    exp_q.push_back(v);
    step;
    net_start = 1'b0;
    check_val("start_ls", 64'(layer_start), 64'd1);
    pop_cmp("start_li", 1'b0, layer_inputs);
    check_val("start_idx", 64'(layer_index), 64'd0);
    check_val("start_busy", 64'(busy), 64'd1);
    check_val("start_err", 64'(error), 64'd0);
  endtask

  // Completes the current WAIT with all valids; returns in WAIT of the next
  // layer, or in DONE for the last layer.
  task automatic finish_layer(input logic [7:0] base, input int next_idx, input bit last);
    agg_values = lanes(base);
    agg_valid  = ALL_VALID;
    if (last) res_q.push_back(lanes(base));
    else      exp_q.push_back(lanes(base));
    step;
    agg_valid = '0;
    if (!last) begin
      check_val("next_ls", 64'(layer_start), 64'd1);
      pop_cmp("next_li", 1'b0, layer_inputs);
      check_val("next_idx", 64'(layer_index), 64'(next_idx));
      step;
      check_val("wait_state", 64'(state_dbg), 64'(ST_WAIT));
      check_val("wait_ls", 64'(layer_start), 64'd0);
    end else begin
      check_val("done_rv", 64'(result_valid), 64'd1);
      pop_cmp("done_res", 1'b1, result_values);
      check_val("done_busy", 64'(busy), 64'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ls"}, 64'(layer_start), 64'd0);
    check_val({tag, "_li"}, 64'(layer_inputs), 64'd0);
    check_val({tag, "_idx"}, 64'(layer_index), 64'd0);
    check_val({tag, "_busy"}, 64'(busy), 64'd0);
    check_val({tag, "_rv"}, 64'(result_valid), 64'd0);
    check_val({tag, "_res"}, 64'(result_values), 64'd0);
    check_val({tag, "_err"}, 64'(error), 64'd0);
    check_val({tag, "_st"}, 64'(state_dbg), 64'(ST_IDLE));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int cycles;
    logic [W-1:0] held;

    repeat (2) step;
    check_all_zero("reset");
    rst = 1'b1;
    step;

    // layer 0 with partial valids that must never latch
    start_net(lanes(8'h10));
    step;
    check_val("l0_wait", 64'(state_dbg), 64'(ST_WAIT));
    agg_values = lanes(8'hA0);
    for (int i = 0; i < NEURONS - 1; i++) begin
      agg_valid[i] = 1'b1;
      step;
      check_val("partial_ls", 64'(layer_start), 64'd0);
      check_val("partial_hold", 64'(layer_inputs), 64'(lanes(8'h10)));
    end
    finish_layer(8'hA0, 1, 1'b0);
    finish_layer(8'hB0, 2, 1'b0);
    finish_layer(8'hC0, 0, 1'b1);

    // result held while consumer stalls; net_start in DONE ignored
    held = lanes(8'hC0);
    for (int i = 0; i < 5; i++) begin
      step;
      check_val("hold_rv", 64'(result_valid), 64'd1);
      check_val("hold_res", 64'(result_values), 64'(held));
    end
    net_inputs = lanes(8'h77);
    net_start  = 1'b1;
    step;
    net_start = 1'b0;
    check_val("done_ign_st", 64'(state_dbg), 64'(ST_DONE));
    check_val("done_ign_idx", 64'(layer_index), 64'd2);
    check_val("done_ign_res", 64'(result_values), 64'(held));
    result_ready = 1'b1;
    step;
    result_ready = 1'b0;
    check_val("accept_rv", 64'(result_valid), 64'd0);
    check_val("accept_st", 64'(state_dbg), 64'(ST_IDLE));

    // net_start while busy ignored, then watchdog
    start_net(lanes(8'h20));
    step;
    cycles = 0;
    net_inputs = lanes(8'h55);
    net_start  = 1'b1;
    agg_valid  = 6'b011111;
    step;
    cycles = 1;
    net_start = 1'b0;
    check_val("busy_ign_li", 64'(layer_inputs), 64'(lanes(8'h20)));
    check_val("busy_ign_idx", 64'(layer_index), 64'd0);
    check_val("busy_ign_ls", 64'(layer_start), 64'd0);
    while (!error && cycles < 2000) begin
      step;
      cycles++;
    end
    check_val("timeout_cycles", 64'(cycles), 64'(TIMEOUT + 1));
    check_val("timeout_busy", 64'(busy), 64'd0);
    check_val("timeout_st", 64'(state_dbg), 64'(ST_ERR));
    step;
    check_val("err_sticky", 64'(error), 64'd1);

    // restart from ERR, then async reset in WAIT of layer 1
    agg_valid = '0;
    start_net(lanes(8'h30));
    step;
    finish_layer(8'hD0, 1, 1'b0);
    #2 rst = 1'b0;
    #1 check_all_zero("async_rst");
    step;
    rst = 1'b1;
    repeat (3) step;
    check_all_zero("post_rst");
    check_val("sb_empty", 64'(exp_q.size() + res_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
